// File: rtl/mips_mmio_resp.sv
// mips_mmio_resp: MMIO responder for the MIPS data bus (region base 0xffff0000).
// Provides a GPIO register pair, a byte transmit FIFO and a compare timer.
//
// Ports:
//   clk, rst                 - core clock, asynchronous active-high reset
//   data_mmio_wr_addr_val    - write strobe; data_mmio_wr_addr / mmio_wr_data
//   data_mmio_rd_addr_val    - read strobe; data_mmio_rd_addr
//   mmio_rd_data(_val)       - registered read data and its one-cycle qualifier
//   mmio_addr_error          - one-cycle pulse for unmapped/unaligned access
//   gpio_in / gpio_out       - GPIO input (2-flop synchronized) and output register
//   tx_valid/tx_data/tx_ready- FIFO drain port (valid/ready)
//   timer_irq                - registered timer_flag & irq_en
module mips_mmio_resp #(
    parameter int TX_FIFO_DEPTH = 4,
    parameter int GPIO_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              data_mmio_wr_addr_val,
    input  logic [31:0]       data_mmio_wr_addr,
    input  logic [31:0]       mmio_wr_data,
    input  logic              data_mmio_rd_addr_val,
    input  logic [31:0]       data_mmio_rd_addr,
    output logic [31:0]       mmio_rd_data,
    output logic              mmio_rd_data_val,
    output logic              mmio_addr_error,
    input  logic [GPIO_W-1:0] gpio_in,
    output logic [GPIO_W-1:0] gpio_out,
    output logic              tx_valid,
    output logic [7:0]        tx_data,
    input  logic              tx_ready,
    output logic              timer_irq
);

    localparam int PW = $clog2(TX_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(TX_FIFO_DEPTH);

    // ---------------- address decode ----------------
    logic [2:0] wr_idx;
    logic [2:0] rd_idx;
    logic       wr_ok;
    logic       rd_ok;
    logic       wr_en;

    assign wr_idx = data_mmio_wr_addr[4:2];
    assign rd_idx = data_mmio_rd_addr[4:2];

    // Offsets 0x00..0x18, word aligned; 0x1C and beyond are unmapped.
    assign wr_ok = (data_mmio_wr_addr[31:5] == 27'd0)
                && (data_mmio_wr_addr[1:0] == 2'b00)
                && (wr_idx != 3'd7);
    assign rd_ok = (data_mmio_rd_addr[31:5] == 27'd0)
                && (data_mmio_rd_addr[1:0] == 2'b00)
                && (rd_idx != 3'd7);

    assign wr_en = data_mmio_wr_addr_val && wr_ok;

    logic wr_gpio;
    logic wr_tx;
    logic wr_cnt;
    logic wr_cmp;
    logic wr_ctrl;

    assign wr_gpio = wr_en && (wr_idx == 3'd0);
    assign wr_tx   = wr_en && (wr_idx == 3'd2);
    assign wr_cnt  = wr_en && (wr_idx == 3'd4);
    assign wr_cmp  = wr_en && (wr_idx == 3'd5);
    assign wr_ctrl = wr_en && (wr_idx == 3'd6);

    // ---------------- GPIO ----------------
    logic [GPIO_W-1:0] gpio_s1;
    logic [GPIO_W-1:0] gpio_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gpio_out <= '0;
            gpio_s1  <= '0;
            gpio_s2  <= '0;
        end else begin
            gpio_s1 <= gpio_in;
            gpio_s2 <= gpio_s1;
            if (wr_gpio)
                gpio_out <= mmio_wr_data[GPIO_W-1:0];
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]    mem [TX_FIFO_DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          pop;
    logic          accept;
    logic          tx_overflow;

    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign tx_valid = !empty;
    assign tx_data  = mem[head];
    assign pop      = tx_valid && tx_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign accept   = wr_tx && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
            for (int i = 0; i < TX_FIFO_DEPTH; i++)
                mem[i] <= 8'd0;
        end else begin
            if (accept) begin
                mem[tail] <= mmio_wr_data[7:0];
                tail      <= tail + PW'(1);
            end
            if (pop)
                head <= head + PW'(1);
            count <= count + CW'(accept) - CW'(pop);
            if (wr_tx && !accept)
                tx_overflow <= 1'b1;
            else if (wr_ctrl && mmio_wr_data[2])
                tx_overflow <= 1'b0;
        end
    end

    // ---------------- timer ----------------
    logic [31:0] timer_cnt;
    logic [31:0] timer_cmp;
    logic        timer_en;
    logic        irq_en;
    logic        timer_flag;
    logic        hit;
    logic        flag_d;
    logic        irq_en_d;

    assign hit = timer_en && (timer_cnt == timer_cmp);

    // A compare hit outranks a same-cycle clear request.
    always_comb begin
        flag_d = timer_flag;
        if (wr_ctrl && mmio_wr_data[1])
            flag_d = 1'b0;
        if (hit)
            flag_d = 1'b1;
        irq_en_d = wr_ctrl ? mmio_wr_data[3] : irq_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_cnt  <= '0;
            timer_cmp  <= '0;
            timer_en   <= 1'b0;
            irq_en     <= 1'b0;
            timer_flag <= 1'b0;
            timer_irq  <= 1'b0;
        end else begin
            if (wr_cnt)
                timer_cnt <= mmio_wr_data;
            else if (timer_en)
                timer_cnt <= hit ? 32'd0 : timer_cnt + 32'd1;
            if (wr_cmp)
                timer_cmp <= mmio_wr_data;
            if (wr_ctrl)
                timer_en <= mmio_wr_data[0];
            irq_en     <= irq_en_d;
            timer_flag <= flag_d;
            // Registered copy of the next flag/irq_en, so no input path.
            timer_irq  <= flag_d && irq_en_d;
        end
    end

    // ---------------- read path ----------------
    logic [31:0] status;
    logic [31:0] rd_word;

    assign status = {18'd0, tx_overflow, timer_flag, 3'd0,
                     5'(count), 2'd0, empty, full};

    always_comb begin
        rd_word = 32'd0;
        if (rd_ok) begin
            case (rd_idx)
                3'd0:    rd_word = 32'(gpio_out);
                3'd1:    rd_word = 32'(gpio_s2);
                3'd3:    rd_word = status;
                3'd4:    rd_word = timer_cnt;
                3'd5:    rd_word = timer_cmp;
                3'd6:    rd_word = {28'd0, irq_en, 2'b00, timer_en};
                default: rd_word = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mmio_rd_data     <= '0;
            mmio_rd_data_val <= 1'b0;
            mmio_addr_error  <= 1'b0;
        end else begin
            mmio_rd_data_val <= data_mmio_rd_addr_val;
            if (data_mmio_rd_addr_val)
                mmio_rd_data <= rd_word;
            mmio_addr_error <= (data_mmio_wr_addr_val && !wr_ok)
                            || (data_mmio_rd_addr_val && !rd_ok);
        end
    end

endmodule

// File: tb/tb_mips_mmio_resp.sv
// tb_mips_mmio_resp: directed self-checking bench for mips_mmio_resp.
// Inputs change 1ns after each rising edge; outputs are sampled there too.
module tb_mips_mmio_resp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_val = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic        rd_val = 1'b0;
    logic [31:0] rd_addr = '0;
    logic [31:0] rd_data;
    logic        rd_data_val;
    logic        addr_error;
    logic [31:0] gpio_in = '0;
    logic [31:0] gpio_out;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int tests = 0;
    int fails = 0;

    mips_mmio_resp #(.TX_FIFO_DEPTH(4), .GPIO_W(32)) dut (
        .clk                   (clk),
        .rst                   (rst),
        .data_mmio_wr_addr_val (wr_val),
        .data_mmio_wr_addr     (wr_addr),
        .mmio_wr_data          (wr_data),
        .data_mmio_rd_addr_val (rd_val),
        .data_mmio_rd_addr     (rd_addr),
        .mmio_rd_data          (rd_data),
        .mmio_rd_data_val      (rd_data_val),
        .mmio_addr_error       (addr_error),
        .gpio_in               (gpio_in),
        .gpio_out              (gpio_out),
        .tx_valid              (tx_valid),
        .tx_data               (tx_data),
        .tx_ready              (tx_ready),
        .timer_irq             (timer_irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        wr_val  = 1'b1;
        wr_addr = a;
        wr_data = d;
        step();
        wr_val  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a,
                      input logic [31:0] exp, input logic exp_err);
        rd_val  = 1'b1;
        rd_addr = a;
        step();
        rd_val  = 1'b0;
        check({tag, "_data"}, rd_data, exp);
        check({tag, "_val"}, 32'(rd_data_val), 32'd1);
        check({tag, "_err"}, 32'(addr_error), 32'(exp_err));
    endtask

    initial begin
        // reset state
        #3;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_val", 32'(rd_data_val), 32'd0);
        check("rst_err", 32'(addr_error), 32'd0);
        check("rst_gpio_out", gpio_out, 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_irq", 32'(timer_irq), 32'd0);
        step();
        rst = 1'b0;
        step();

        // GPIO
        wr(32'h00, 32'hA5A5_0F0F);
        check("gpio_out", gpio_out, 32'hA5A5_0F0F);
        rd("gpio_rd", 32'h00, 32'hA5A5_0F0F, 1'b0);
        step();
        check("rd_val_pulse", 32'(rd_data_val), 32'd0);
        check("rd_data_hold", rd_data, 32'hA5A5_0F0F);
        gpio_in = 32'h1234_5678;
        step();
        step();
        rd("gpio_in", 32'h04, 32'h1234_5678, 1'b0);

        // FIFO overflow and drain
        tx_ready = 1'b0;
        wr(32'h08, 32'h11);
        check("tx_valid_push", 32'(tx_valid), 32'd1);
        check("tx_head_11", 32'(tx_data), 32'h11);
        wr(32'h08, 32'h22);
        wr(32'h08, 32'h33);
        wr(32'h08, 32'h44);
        wr(32'h08, 32'h55);
        rd("status_full", 32'h0C, 32'h0000_2041, 1'b0);
        rd("tx_data_rd", 32'h08, 32'h0, 1'b0);
        tx_ready = 1'b1;
        check("drain0", 32'(tx_data), 32'h11);
        step();
        check("drain1", 32'(tx_data), 32'h22);
        step();
        check("drain2", 32'(tx_data), 32'h33);
        step();
        check("drain3", 32'(tx_data), 32'h44);
        step();
        check("drained_valid", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;
        rd("status_empty_ovf", 32'h0C, 32'h0000_2002, 1'b0);
        wr(32'h18, 32'h4);
        rd("status_ovf_clr", 32'h0C, 32'h0000_0002, 1'b0);

        // push into a full FIFO while popping
        wr(32'h08, 32'hA1);
        wr(32'h08, 32'hA2);
        wr(32'h08, 32'hA3);
        wr(32'h08, 32'hA4);
        tx_ready = 1'b1;
        wr(32'h08, 32'h66);
        tx_ready = 1'b0;
        rd("status_full_nopovf", 32'h0C, 32'h0000_0041, 1'b0);
        tx_ready = 1'b1;
        check("pp_drain0", 32'(tx_data), 32'hA2);
        step();
        check("pp_drain1", 32'(tx_data), 32'hA3);
        step();
        check("pp_drain2", 32'(tx_data), 32'hA4);
        step();
        check("pp_drain3", 32'(tx_data), 32'h66);
        step();
        check("pp_empty", 32'(tx_valid), 32'd0);
        tx_ready = 1'b0;

        // timer compare sequence
        wr(32'h14, 32'd3);
        wr(32'h18, 32'h9);
        rd("cnt0", 32'h10, 32'd0, 1'b0);
        rd("cnt1", 32'h10, 32'd1, 1'b0);
        rd("cnt2", 32'h10, 32'd2, 1'b0);
        check("irq_before_hit", 32'(timer_irq), 32'd0);
        rd("cnt3", 32'h10, 32'd3, 1'b0);
        check("irq_after_hit", 32'(timer_irq), 32'd1);
        rd("cnt_wrap", 32'h10, 32'd0, 1'b0);
        rd("ctrl_rd", 32'h18, 32'h9, 1'b0);
        // cnt is 2 now; clear away from a hit
        wr(32'h18, 32'hB);
        check("irq_cleared", 32'(timer_irq), 32'd0);
        // cnt 3 -> hit
        step();
        check("irq_rehit", 32'(timer_irq), 32'd1);
        step();
        step();
        step();
        // cnt is 3: clear coincides with hit, set wins
        wr(32'h18, 32'hB);
        check("irq_set_wins", 32'(timer_irq), 32'd1);
        rd("status_flag", 32'h0C, 32'h0000_1002, 1'b0);
        wr(32'h18, 32'h0);
        check("irq_disabled", 32'(timer_irq), 32'd0);
        wr(32'h10, 32'h55);
        rd("cnt_hold0", 32'h10, 32'h55, 1'b0);
        rd("cnt_hold1", 32'h10, 32'h55, 1'b0);
        wr(32'h10, 32'hFFFF_FFFF);
        wr(32'h14, 32'd5);
        wr(32'h18, 32'h1);
        rd("cnt_max", 32'h10, 32'hFFFF_FFFF, 1'b0);
        rd("cnt_rollover", 32'h10, 32'd0, 1'b0);
        wr(32'h18, 32'h0);

        // address errors
        rd("err_1c", 32'h1C, 32'd0, 1'b1);
        rd("err_02", 32'h02, 32'd0, 1'b1);
        wr(32'h20, 32'h0);
        check("err_wr20", 32'(addr_error), 32'd1);
        check("err_wr20_gpio", gpio_out, 32'hA5A5_0F0F);
        step();
        check("err_pulse_end", 32'(addr_error), 32'd0);

        // same-cycle write and read returns old value
        wr_val  = 1'b1;
        wr_addr = 32'h00;
        wr_data = 32'h0000_0001;
        rd_val  = 1'b1;
        rd_addr = 32'h00;
        step();
        wr_val  = 1'b0;
        rd_val  = 1'b0;
        check("rw_old", rd_data, 32'hA5A5_0F0F);
        rd("rw_new", 32'h00, 32'h1, 1'b0);

        // reset mid-operation
        wr(32'h08, 32'h01);
        wr(32'h08, 32'h02);
        wr(32'h08, 32'h03);
        rd_val  = 1'b1;
        rd_addr = 32'h0C;
        step();
        rd_val  = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check("arst_rd_val", 32'(rd_data_val), 32'd0);
        check("arst_rd_data", rd_data, 32'd0);
        check("arst_tx_valid", 32'(tx_valid), 32'd0);
        check("arst_tx_data", 32'(tx_data), 32'd0);
        check("arst_gpio_out", gpio_out, 32'd0);
        rd_val = 1'b0;
        step();
        rst = 1'b0;
        step();
        check("post_rst_rd_val", 32'(rd_data_val), 32'd0);
        check("post_rst_tx_valid", 32'(tx_valid), 32'd0);
        rd("post_rst_status", 32'h0C, 32'h0000_0002, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
